// File: rtl/cmd_multi_val_pkg.sv
// Shared constants, FSM encoding and byte helpers for the multi-key command parser.
package cmd_pkg;

   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_SP = 8'h20;
   localparam logic [7:0] CHAR_0  = 8'h30;
   localparam logic [7:0] CHAR_9  = 8'h39;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PKT    = 2'd1,
      IGNORE = 2'd2
   } state_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CHAR_0) && (b <= CHAR_9);
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == CHAR_LF) || (b == CHAR_CR);
   endfunction

endpackage

// File: rtl/cmd_multi_val_if.sv
// Byte-in / per-channel-value-out bundle between the UART receiver and the parser.
interface cmd_multi_val_if #(
   parameter int NUM_KEYS = 4,
   parameter int VAL_BITS = 8
);
   logic [7:0]                   in_byte;
   logic                         latch;
   logic [NUM_KEYS-1:0]          match;
   logic [NUM_KEYS*VAL_BITS-1:0] values;
   logic                         error;
   logic                         busy;

   modport master (
      output in_byte, latch,
      input  match, values, error, busy
   );

   modport slave (
      input  in_byte, latch,
      output match, values, error, busy
   );
endinterface

// File: rtl/cmd_multi_val_dec_accum.sv
// One decimal digit step: acc*10 + digit in a 4-bit-wider domain, saturating on overflow.
module dec_accum #(
   parameter int VAL_BITS = 8
) (
   input  logic [VAL_BITS-1:0] acc,
   input  logic [3:0]          digit,
   output logic [VAL_BITS-1:0] acc_next,
   output logic                ovf
);
   localparam int W = VAL_BITS + 4;

   logic [W-1:0] wide_acc;
   logic [W-1:0] wide;

   // 10*(2^V-1)+9 < 2^(V+4), so the wide sum can never wrap
   assign wide_acc = {4'b0, acc};
   assign wide     = (wide_acc << 3) + (wide_acc << 1) + {{VAL_BITS{1'b0}}, digit};
   assign ovf      = |wide[W-1:VAL_BITS];
   assign acc_next = ovf ? {VAL_BITS{1'b1}} : wide[VAL_BITS-1:0];
endmodule

// File: rtl/cmd_multi_val.sv
// Multi-channel ASCII "<key><decimal><CR|LF>" parser with a per-key committed value bank.
module cmd_multi_val
   import cmd_pkg::*;
#(
   parameter int                      NUM_KEYS = 4,
   parameter logic [8*NUM_KEYS-1:0]   KEYS     = "wdtc",
   parameter int                      VAL_BITS = 8
) (
   input  logic         clk,
   input  logic         rst,
   cmd_multi_val_if.slave bus
);
   localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   state_t                 state_q, state_d;
   logic [VAL_BITS-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]       ch_q, ch_d;
   logic                   seen_q, seen_d;
   logic                   ovf_q, ovf_d;
   logic                   commit, err_d;
   logic [NUM_KEYS-1:0]    match_q;
   logic                   error_q;
   logic [NUM_KEYS-1:0][VAL_BITS-1:0] val_q;

   logic                   key_hit;
   logic [IDX_W-1:0]       key_idx;
   logic [VAL_BITS-1:0]    acc_nxt;
   logic                   acc_ovf;

   // scan high-to-low so the lowest matching index is the one left standing
   always_comb begin
      key_hit = 1'b0;
      key_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (bus.in_byte == KEYS[8*i +: 8]) begin
            key_hit = 1'b1;
            key_idx = IDX_W'(i);
         end
      end
   end

   dec_accum #(.VAL_BITS(VAL_BITS)) u_accum (
      .acc      (acc_q),
      .digit    (bus.in_byte[3:0]),
      .acc_next (acc_nxt),
      .ovf      (acc_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ch_q    <= '0;
         seen_q  <= 1'b0;
         ovf_q   <= 1'b0;
         match_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ch_q    <= ch_d;
         seen_q  <= seen_d;
         ovf_q   <= ovf_d;
         match_q <= commit ? (NUM_KEYS'(1) << ch_q) : '0;
         error_q <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ch_d    = ch_q;
      seen_d  = seen_q;
      ovf_d   = ovf_q;
      commit  = 1'b0;
      err_d   = 1'b0;
      if (bus.latch) begin
         unique case (state_q)
            IDLE: begin
               if (key_hit) begin
                  state_d = PKT;
                  ch_d    = key_idx;
                  acc_d   = '0;
                  seen_d  = 1'b0;
                  ovf_d   = 1'b0;
               end else if (!is_term(bus.in_byte)) begin
                  // stray bytes are dropped silently; terminators (CRLF tail) stay idle
                  state_d = IGNORE;
               end
            end
            PKT: begin
               if (is_digit(bus.in_byte)) begin
                  acc_d  = acc_nxt;
                  ovf_d  = ovf_q | acc_ovf;
                  seen_d = 1'b1;
               end else if (is_term(bus.in_byte)) begin
                  state_d = IDLE;
                  if (seen_q && !ovf_q) commit = 1'b1;
                  else                  err_d  = 1'b1;
               end else if (bus.in_byte != CHAR_SP) begin
                  err_d   = 1'b1;
                  state_d = IGNORE;
               end
            end
            IGNORE: begin
               if (is_term(bus.in_byte)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                  val_q[i] <= '0;
         else if (commit && ch_q == IDX_W'(i))     val_q[i] <= acc_q;
      end
   end

   assign bus.match  = match_q;
   assign bus.error  = error_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.values = val_q;
endmodule
